// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter that shares the eight output lines of one 3-to-8 decoder
// among eight requesters. The winner's index is driven onto the decoder
// selects, and the decoder enable is asserted while the grant lasts. Each grant
// is bounded by MAX_HOLD cycles. A one-cycle gap with the enable low separates
// any two grants, so two decoded lines are never active in consecutive cycles.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per requester (0 = unlimited)
//   CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   en         in   arbiter enable; low blocks new grants and revokes the
//                   active one
//   req[7:0]   in   request vector, req[i] held high by requester i until done
//   dec_e      out  decoder enable (registered)
//   dec_a      out  decoder select MSB, grant_idx[2] (registered)
//   dec_b      out  decoder select, grant_idx[1] (registered)
//   dec_c      out  decoder select LSB, grant_idx[0] (registered)
//   grant_idx  out  index of the current or most recent grantee
//   expired    out  one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic       dec_e,
  output logic       dec_a,
  output logic       dec_b,
  output logic       dec_c,
  output logic [2:0] grant_idx,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Hold-counter value seen in the last permitted grant cycle. Unused when
  // MAX_HOLD is 0, but kept in range so the constant stays well defined.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             dec_e_q, dec_e_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       last_q, last_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             pick_found;
  logic [2:0]       pick_idx;
  logic [2:0]       cand;

  // ---------------------------------------------------------------------------
  // Round-robin pick. Candidates are visited from lowest to highest priority
  // (last itself first, then last-1 down to last+1) so that a later, higher
  // priority hit overwrites an earlier one. The previous grantee therefore
  // only wins when it is the sole requester.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int off = 8; off >= 1; off--) begin
      cand = last_q + 3'(off);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. dec_e_d is high exactly when the next
  // state is GRANT, so the registered enable tracks the grant with no extra
  // decoding on the output.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dec_e_d   = 1'b0;
    idx_d     = idx_q;
    last_d    = last_q;
    expired_d = 1'b0;
    hold_d    = hold_q;

    unique case (state_q)
      IDLE, GAP: begin
        // A GAP cycle arbitrates exactly like IDLE; its only role is that the
        // enable was forced low for this one cycle.
        if (en && pick_found) begin
          state_d = GRANT;
          dec_e_d = 1'b1;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT: begin
        if (!en || !req[idx_q]) begin
          // Voluntary release or enable drop: revoke without the expiry pulse.
          state_d = GAP;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          state_d   = GAP;
          expired_d = 1'b1;
        end else begin
          dec_e_d = 1'b1;
          hold_d  = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Selects and grant_idx hold their value while
  // the enable is low; only dec_e gates the decoder.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of the others, regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      dec_e_q   <= 1'b0;
      idx_q     <= 3'd0;
      last_q    <= 3'd7;  // makes index 0 the first winner after reset
      expired_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      dec_e_q   <= dec_e_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      expired_q <= expired_d;
      hold_q    <= hold_d;
    end
  end

  assign dec_e     = dec_e_q;
  assign dec_a     = idx_q[2];
  assign dec_b     = idx_q[1];
  assign dec_c     = idx_q[0];
  assign grant_idx = idx_q;
  assign expired   = expired_q;

  // An expiry pulse always coincides with the gap cycle.
  a_expired_in_gap : assert property (
    @(posedge clk) disable iff (rst) expired |-> !dec_e
  );

  // The selects never move while a grant is being held.
  a_stable_select : assert property (
    @(posedge clk) disable iff (rst)
      (dec_e && $past(dec_e)) |-> (grant_idx == $past(grant_idx))
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Two arbiters: dut_a with the default hold limit of 4, dut_b with unlimited
// hold. A directed vector list drives one DUT per cycle on the falling edge and
// pushes the hand-computed response expected after the next rising edge into a
// scoreboard queue. An independent monitor pops and compares just after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: MAX_HOLD = 4
  logic       rst_a = 1'b1;
  logic       en_a  = 1'b0;
  logic [7:0] req_a = 8'h00;
  logic       e_a, a_a, b_a, c_a, x_a;
  logic [2:0] gi_a;

  // dut_b: MAX_HOLD = 0 (unlimited)
  logic       rst_b = 1'b1;
  logic       en_b  = 1'b0;
  logic [7:0] req_b = 8'h00;
  logic       e_b, a_b, b_b, c_b, x_b;
  logic [2:0] gi_b;

  decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .req(req_a),
    .dec_e(e_a), .dec_a(a_a), .dec_b(b_a), .dec_c(c_a),
    .grant_idx(gi_a), .expired(x_a)
  );

  decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .req(req_b),
    .dec_e(e_b), .dec_a(a_b), .dec_b(b_b), .dec_c(c_b),
    .grant_idx(gi_b), .expired(x_b)
  );

  typedef struct {
    int         cyc;
    int         vnum;
    bit         sel;
    bit         e;
    logic [2:0] idx;
    bit         x;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   vnum  = 0;

  task automatic check(input string name, input int vn,
                       input logic [7:0] act, input logic [7:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s v%0d: got %0h, expected %0h", name, vn, act, want);
    end
  endtask

  // One directed vector: inputs for the next rising edge plus the outputs
  // expected right after it.
  task automatic vec(input bit sel, input bit r, input bit en_in,
                     input logic [7:0] rq, input bit e,
                     input logic [2:0] idx, input bit x);
    exp_t t;
    @(negedge clk);
    if (!sel) begin
      rst_a = r; en_a = en_in; req_a = rq;
    end else begin
      rst_b = r; en_b = en_in; req_b = rq;
    end
    t.cyc  = cyc + 1;
    t.vnum = vnum;
    t.sel  = sel;
    t.e    = e;
    t.idx  = idx;
    t.x    = x;
    sb.push_back(t);
    vnum++;
  endtask

  // Monitor: counts rising edges and checks every expectation due by now.
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        t = sb.pop_front();
        if (!t.sel) begin
          check("a_dec_e",     t.vnum, {7'd0, e_a},            {7'd0, t.e});
          check("a_abc",       t.vnum, {5'd0, a_a, b_a, c_a},  {5'd0, t.idx});
          check("a_grant_idx", t.vnum, {5'd0, gi_a},           {5'd0, t.idx});
          check("a_expired",   t.vnum, {7'd0, x_a},            {7'd0, t.x});
        end else begin
          check("b_dec_e",     t.vnum, {7'd0, e_b},            {7'd0, t.e});
          check("b_abc",       t.vnum, {5'd0, a_b, b_b, c_b},  {5'd0, t.idx});
          check("b_grant_idx", t.vnum, {5'd0, gi_b},           {5'd0, t.idx});
          check("b_expired",   t.vnum, {7'd0, x_b},            {7'd0, t.x});
        end
      end
    end
  end

  initial begin
    // --- reset + single request ------------------------------------------
    vec(0, 1, 1, 8'h00, 0, 3'd0, 0);  // v0  reset state
    vec(0, 0, 1, 8'h01, 1, 3'd0, 0);  // v1  one-cycle latency, index 0
    vec(0, 0, 1, 8'h01, 1, 3'd0, 0);  // v2
    vec(0, 0, 1, 8'h00, 0, 3'd0, 0);  // v3  release -> gap
    vec(0, 0, 1, 8'h00, 0, 3'd0, 0);  // v4  idle

    // --- round-robin with hold limit, req = 0x81 -------------------------
    vec(0, 1, 1, 8'h81, 0, 3'd0, 0);  // v5  reset again: last = 7
    vec(0, 0, 1, 8'h81, 1, 3'd0, 0);  // v6  grant 0
    vec(0, 0, 1, 8'h81, 1, 3'd0, 0);  // v7
    vec(0, 0, 1, 8'h81, 1, 3'd0, 0);  // v8
    vec(0, 0, 1, 8'h81, 1, 3'd0, 0);  // v9  fourth grant cycle
    vec(0, 0, 1, 8'h81, 0, 3'd0, 1);  // v10 expired, gap
    vec(0, 0, 1, 8'h81, 1, 3'd7, 0);  // v11 grant 7
    vec(0, 0, 1, 8'h81, 1, 3'd7, 0);  // v12
    vec(0, 0, 1, 8'h81, 1, 3'd7, 0);  // v13
    vec(0, 0, 1, 8'h81, 1, 3'd7, 0);  // v14
    vec(0, 0, 1, 8'h81, 0, 3'd7, 1);  // v15 expired, gap
    vec(0, 0, 1, 8'h81, 1, 3'd0, 0);  // v16 back to 0

    // --- wrap-around: last = 6, req = 0x41 -> 0 --------------------------
    vec(0, 0, 1, 8'h00, 0, 3'd0, 0);  // v17 gap
    vec(0, 0, 1, 8'h40, 1, 3'd6, 0);  // v18 grant 6
    vec(0, 0, 1, 8'h00, 0, 3'd6, 0);  // v19 gap
    vec(0, 0, 1, 8'h41, 1, 3'd0, 0);  // v20 search 7 -> 0
    vec(0, 0, 1, 8'h00, 0, 3'd0, 0);  // v21 gap

    // --- early release of index 3, then a full-length re-grant -----------
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v22 grant 3
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v23
    vec(0, 0, 1, 8'h00, 0, 3'd3, 0);  // v24 release, no expiry
    vec(0, 0, 1, 8'h00, 0, 3'd3, 0);  // v25 idle
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v26 sole requester wins again
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v27
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v28
    vec(0, 0, 1, 8'h08, 1, 3'd3, 0);  // v29 counter restarted at 0
    vec(0, 0, 1, 8'h08, 0, 3'd3, 1);  // v30 expired
    vec(0, 0, 1, 8'h00, 0, 3'd3, 0);  // v31 idle

    // --- enable drop and reset mid-grant ---------------------------------
    vec(0, 0, 1, 8'h20, 1, 3'd5, 0);  // v32 grant 5
    vec(0, 0, 1, 8'h20, 1, 3'd5, 0);  // v33
    vec(0, 0, 0, 8'h20, 0, 3'd5, 0);  // v34 en = 0 revokes
    vec(0, 0, 0, 8'h20, 0, 3'd5, 0);  // v35 no grant while en = 0
    vec(0, 0, 0, 8'hFF, 0, 3'd5, 0);  // v36
    vec(0, 0, 1, 8'h20, 1, 3'd5, 0);  // v37 re-enabled
    vec(0, 1, 1, 8'h20, 0, 3'd0, 0);  // v38 reset mid-grant
    vec(0, 0, 1, 8'hFF, 1, 3'd0, 0);  // v39 all requesting after reset -> 0
    vec(0, 0, 1, 8'hFF, 1, 3'd0, 0);  // v40
    vec(0, 0, 1, 8'h00, 0, 3'd0, 0);  // v41 release

    // --- unlimited hold on dut_b, req = 0x10 for 20 cycles ---------------
    vec(1, 1, 1, 8'h00, 0, 3'd0, 0);  // reset state
    for (int i = 0; i < 20; i++) begin
      vec(1, 0, 1, 8'h10, 1, 3'd4, 0);
    end
    vec(1, 0, 1, 8'h00, 0, 3'd4, 0);  // release

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
